// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed ALU/branch ops until both operands are valid, issues one per cycle.
// Optional build macro RS_PERF_COUNTER_EN adds perf_issue_cnt / perf_full_cnt outputs.
module alu_reservation_station #(
   parameter int RS_SIZE = 16,
   parameter int ROB_W   = 4,
   parameter int OP_W    = 6,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              jump_wrong,
   input  logic              dispatch_valid,
   input  logic [OP_W-1:0]   dispatch_op,
   input  logic [DATA_W-1:0] dispatch_pc,
   input  logic [DATA_W-1:0] dispatch_imm,
   input  logic [ROB_W-1:0]  dispatch_rd_rename,
   input  logic              dispatch_rs1_ready,
   input  logic [DATA_W-1:0] dispatch_rs1_value,
   input  logic [ROB_W-1:0]  dispatch_rs1_rename,
   input  logic              dispatch_rs2_ready,
   input  logic [DATA_W-1:0] dispatch_rs2_value,
   input  logic [ROB_W-1:0]  dispatch_rs2_rename,
   output logic              rs_full,
   input  logic              alu_cdb_valid,
   input  logic [ROB_W-1:0]  alu_cdb_rename,
   input  logic [DATA_W-1:0] alu_cdb_value,
   input  logic              lsb_cdb_valid,
   input  logic [ROB_W-1:0]  lsb_cdb_rename,
   input  logic [DATA_W-1:0] lsb_cdb_value,
   output logic              alu_enable,
   output logic [ROB_W-1:0]  out_rd_rename,
   output logic [OP_W-1:0]   out_op,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_rs1_value,
   output logic [DATA_W-1:0] out_rs2_value
`ifdef RS_PERF_COUNTER_EN
   ,
   output logic [31:0]       perf_issue_cnt,
   output logic [31:0]       perf_full_cnt
`endif
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   typedef struct packed {
      logic              rdy;
      logic [DATA_W-1:0] val;
      logic [ROB_W-1:0]  ren;
   } src_t;

   typedef struct packed {
      logic              busy;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] imm;
      logic [ROB_W-1:0]  rd;
      src_t              s1;
      src_t              s2;
   } entry_t;

   entry_t ent_q [RS_SIZE];
   entry_t ent_d [RS_SIZE];

   logic              alu_en_q, alu_en_d;
   logic [ROB_W-1:0]  out_rd_q, out_rd_d;
   logic [OP_W-1:0]   out_op_q, out_op_d;
   logic [DATA_W-1:0] out_pc_q, out_pc_d;
   logic [DATA_W-1:0] out_imm_q, out_imm_d;
   logic [DATA_W-1:0] out_v1_q, out_v1_d;
   logic [DATA_W-1:0] out_v2_q, out_v2_d;

   logic              free_found, iss_found;
   logic [IDX_W-1:0]  free_idx, iss_idx;
   entry_t            new_ent;

   // ALU bus takes precedence when both buses carry the same tag.
   function automatic src_t snoop(input src_t s,
                                  input logic av, input logic [ROB_W-1:0] at, input logic [DATA_W-1:0] ad,
                                  input logic lv, input logic [ROB_W-1:0] lt, input logic [DATA_W-1:0] ld);
      snoop = s;
      if (!s.rdy) begin
         if (av && (at == s.ren)) begin
            snoop.rdy = 1'b1;
            snoop.val = ad;
         end else if (lv && (lt == s.ren)) begin
            snoop.rdy = 1'b1;
            snoop.val = ld;
         end
      end
   endfunction

   // Descending scans leave the lowest matching index selected.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      iss_found  = 1'b0;
      iss_idx    = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!ent_q[i].busy) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (ent_q[i].busy && ent_q[i].s1.rdy && ent_q[i].s2.rdy) begin
            iss_found = 1'b1;
            iss_idx   = IDX_W'(i);
         end
      end
   end

   assign rs_full = ~free_found;

   always_comb begin
      new_ent.busy = 1'b1;
      new_ent.op   = dispatch_op;
      new_ent.pc   = dispatch_pc;
      new_ent.imm  = dispatch_imm;
      new_ent.rd   = dispatch_rd_rename;
      new_ent.s1   = snoop('{rdy: dispatch_rs1_ready, val: dispatch_rs1_value, ren: dispatch_rs1_rename},
                           alu_cdb_valid, alu_cdb_rename, alu_cdb_value,
                           lsb_cdb_valid, lsb_cdb_rename, lsb_cdb_value);
      new_ent.s2   = snoop('{rdy: dispatch_rs2_ready, val: dispatch_rs2_value, ren: dispatch_rs2_rename},
                           alu_cdb_valid, alu_cdb_rename, alu_cdb_value,
                           lsb_cdb_valid, lsb_cdb_rename, lsb_cdb_value);
   end

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i] = ent_q[i];
      alu_en_d  = 1'b0;
      out_rd_d  = out_rd_q;
      out_op_d  = out_op_q;
      out_pc_d  = out_pc_q;
      out_imm_d = out_imm_q;
      out_v1_d  = out_v1_q;
      out_v2_d  = out_v2_q;
      if (jump_wrong) begin
         for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_q[i].busy) begin
               ent_d[i].s1 = snoop(ent_q[i].s1, alu_cdb_valid, alu_cdb_rename, alu_cdb_value,
                                   lsb_cdb_valid, lsb_cdb_rename, lsb_cdb_value);
               ent_d[i].s2 = snoop(ent_q[i].s2, alu_cdb_valid, alu_cdb_rename, alu_cdb_value,
                                   lsb_cdb_valid, lsb_cdb_rename, lsb_cdb_value);
            end
         end
         if (iss_found) begin
            ent_d[iss_idx].busy = 1'b0;
            alu_en_d  = 1'b1;
            out_rd_d  = ent_q[iss_idx].rd;
            out_op_d  = ent_q[iss_idx].op;
            out_pc_d  = ent_q[iss_idx].pc;
            out_imm_d = ent_q[iss_idx].imm;
            out_v1_d  = ent_q[iss_idx].s1.val;
            out_v2_d  = ent_q[iss_idx].s2.val;
         end
         // free_idx comes from registered busy bits, so a slot issued this cycle stays unavailable.
         if (dispatch_valid && free_found) ent_d[free_idx] = new_ent;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
         alu_en_q  <= 1'b0;
         out_rd_q  <= '0;
         out_op_q  <= '0;
         out_pc_q  <= '0;
         out_imm_q <= '0;
         out_v1_q  <= '0;
         out_v2_q  <= '0;
      end else if (rdy) begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
         alu_en_q  <= alu_en_d;
         out_rd_q  <= out_rd_d;
         out_op_q  <= out_op_d;
         out_pc_q  <= out_pc_d;
         out_imm_q <= out_imm_d;
         out_v1_q  <= out_v1_d;
         out_v2_q  <= out_v2_d;
      end else begin
         alu_en_q <= 1'b0;
      end
   end

   assign alu_enable    = alu_en_q;
   assign out_rd_rename = out_rd_q;
   assign out_op        = out_op_q;
   assign out_pc        = out_pc_q;
   assign out_imm       = out_imm_q;
   assign out_rs1_value = out_v1_q;
   assign out_rs2_value = out_v2_q;

`ifdef RS_PERF_COUNTER_EN
   logic [31:0] perf_issue_q, perf_full_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issue_q <= '0;
         perf_full_q  <= '0;
      end else if (rdy) begin
         if (alu_en_d) perf_issue_q <= perf_issue_q + 32'd1;
         if (rs_full)  perf_full_q  <= perf_full_q + 32'd1;
      end
   end

   assign perf_issue_cnt = perf_issue_q;
   assign perf_full_cnt  = perf_full_q;
`endif

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: vector table for single-entry flows, hand sequences for fill/flush/priority.
module tb_alu_reservation_station;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_wrong, dispatch_valid;
   logic [5:0]  dispatch_op;
   logic [31:0] dispatch_pc, dispatch_imm;
   logic [3:0]  dispatch_rd_rename;
   logic        dispatch_rs1_ready, dispatch_rs2_ready;
   logic [31:0] dispatch_rs1_value, dispatch_rs2_value;
   logic [3:0]  dispatch_rs1_rename, dispatch_rs2_rename;
   logic        rs_full;
   logic        alu_cdb_valid, lsb_cdb_valid;
   logic [3:0]  alu_cdb_rename, lsb_cdb_rename;
   logic [31:0] alu_cdb_value, lsb_cdb_value;
   logic        alu_enable;
   logic [3:0]  out_rd_rename;
   logic [5:0]  out_op;
   logic [31:0] out_pc, out_imm, out_rs1_value, out_rs2_value;

   alu_reservation_station dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
      .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op), .dispatch_pc(dispatch_pc),
      .dispatch_imm(dispatch_imm), .dispatch_rd_rename(dispatch_rd_rename),
      .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs1_value(dispatch_rs1_value),
      .dispatch_rs1_rename(dispatch_rs1_rename),
      .dispatch_rs2_ready(dispatch_rs2_ready), .dispatch_rs2_value(dispatch_rs2_value),
      .dispatch_rs2_rename(dispatch_rs2_rename),
      .rs_full(rs_full),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rename(alu_cdb_rename), .alu_cdb_value(alu_cdb_value),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rename(lsb_cdb_rename), .lsb_cdb_value(lsb_cdb_value),
      .alu_enable(alu_enable), .out_rd_rename(out_rd_rename), .out_op(out_op), .out_pc(out_pc),
      .out_imm(out_imm), .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy, dv;
      logic [5:0]  op;
      logic [31:0] pc, imm;
      logic [3:0]  rd;
      logic        r1;
      logic [31:0] v1;
      logic [3:0]  t1;
      logic        r2;
      logic [31:0] v2;
      logic [3:0]  t2;
      logic        av;
      logic [3:0]  at;
      logic [31:0] ad;
      logic        lv;
      logic [3:0]  lt;
      logic [31:0] ld;
      logic        e_en;
      logic [5:0]  e_op;
      logic [31:0] e_pc, e_imm;
      logic [3:0]  e_rd;
      logic [31:0] e_v1, e_v2;
   } vec_t;

   vec_t tbl[$];
   vec_t cur;
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      rdy = 1'b1; jump_wrong = 1'b0; dispatch_valid = 1'b0;
      dispatch_op = '0; dispatch_pc = '0; dispatch_imm = '0; dispatch_rd_rename = '0;
      dispatch_rs1_ready = 1'b0; dispatch_rs1_value = '0; dispatch_rs1_rename = '0;
      dispatch_rs2_ready = 1'b0; dispatch_rs2_value = '0; dispatch_rs2_rename = '0;
      alu_cdb_valid = 1'b0; alu_cdb_rename = '0; alu_cdb_value = '0;
      lsb_cdb_valid = 1'b0; lsb_cdb_rename = '0; lsb_cdb_value = '0;
   endtask

   task automatic drv_disp(input logic [5:0] op, input logic [31:0] pc, input logic [3:0] rd,
                           input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                           input logic r2, input logic [31:0] v2, input logic [3:0] t2);
      dispatch_valid = 1'b1; dispatch_op = op; dispatch_pc = pc; dispatch_imm = 32'h0;
      dispatch_rd_rename = rd;
      dispatch_rs1_ready = r1; dispatch_rs1_value = v1; dispatch_rs1_rename = t1;
      dispatch_rs2_ready = r2; dispatch_rs2_value = v2; dispatch_rs2_rename = t2;
   endtask

   // Row builders: input setters edit cur, e() appends the row with its expected outputs.
   function automatic vec_t blank();
      vec_t r;
      r = '{default: '0};
      r.rdy = 1'b1;
      return r;
   endfunction

   task automatic d(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rd,
                    input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                    input logic r2, input logic [31:0] v2, input logic [3:0] t2);
      cur.dv = 1'b1; cur.op = op; cur.pc = pc; cur.imm = imm; cur.rd = rd;
      cur.r1 = r1; cur.v1 = v1; cur.t1 = t1; cur.r2 = r2; cur.v2 = v2; cur.t2 = t2;
   endtask

   task automatic ca(input logic [3:0] t, input logic [31:0] v);
      cur.av = 1'b1; cur.at = t; cur.ad = v;
   endtask

   task automatic cl(input logic [3:0] t, input logic [31:0] v);
      cur.lv = 1'b1; cur.lt = t; cur.ld = v;
   endtask

   task automatic e(input logic en, input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                    input logic [3:0] rd, input logic [31:0] v1, input logic [31:0] v2);
      cur.e_en = en; cur.e_op = op; cur.e_pc = pc; cur.e_imm = imm; cur.e_rd = rd;
      cur.e_v1 = v1; cur.e_v2 = v2;
      tbl.push_back(cur);
      cur = blank();
   endtask

   initial begin
      cur = blank();
      // plain ADD, both ready
      d(6'd1, 32'h100, 32'h4, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0); e(1'b0, 6'd0, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0);
      e(1'b1, 6'd1, 32'h100, 32'h4, 4'd3, 32'd5, 32'd7);
      e(1'b0, 6'd1, 32'h100, 32'h4, 4'd3, 32'd5, 32'd7);
      // SUB waiting on tag 9, woken two cycles later by the ALU bus
      d(6'd2, 32'h104, 32'h0, 4'd5, 1'b0, 32'hdead, 4'd9, 1'b1, 32'h22, 4'd0); e(1'b0, 6'd1, 32'h100, 32'h4, 4'd3, 32'd5, 32'd7);
      e(1'b0, 6'd1, 32'h100, 32'h4, 4'd3, 32'd5, 32'd7);
      ca(4'd9, 32'h10); e(1'b0, 6'd1, 32'h100, 32'h4, 4'd3, 32'd5, 32'd7);
      e(1'b1, 6'd2, 32'h104, 32'h0, 4'd5, 32'h10, 32'h22);
      e(1'b0, 6'd2, 32'h104, 32'h0, 4'd5, 32'h10, 32'h22);
      // dispatch bypass from the LSB bus; ALU bus carries an unrelated tag
      d(6'd3, 32'h108, 32'hfffffff0, 4'd6, 1'b1, 32'd1, 4'd0, 1'b0, 32'h0, 4'd4);
      ca(4'd6, 32'h55); cl(4'd4, 32'hAB); e(1'b0, 6'd2, 32'h104, 32'h0, 4'd5, 32'h10, 32'h22);
      e(1'b1, 6'd3, 32'h108, 32'hfffffff0, 4'd6, 32'd1, 32'hAB);
      // both buses match at dispatch: ALU value wins
      d(6'd4, 32'h10c, 32'h8, 4'd7, 1'b0, 32'h0, 4'd7, 1'b1, 32'd2, 4'd0);
      ca(4'd7, 32'h77); cl(4'd7, 32'h88); e(1'b0, 6'd3, 32'h108, 32'hfffffff0, 4'd6, 32'd1, 32'hAB);
      e(1'b1, 6'd4, 32'h10c, 32'h8, 4'd7, 32'h77, 32'd2);
      e(1'b0, 6'd4, 32'h10c, 32'h8, 4'd7, 32'h77, 32'd2);
      // broadcast during rdy=0 is not captured; a later one is
      d(6'd5, 32'h110, 32'h0, 4'd8, 1'b0, 32'h0, 4'd8, 1'b1, 32'd3, 4'd0); e(1'b0, 6'd4, 32'h10c, 32'h8, 4'd7, 32'h77, 32'd2);
      cur.rdy = 1'b0; ca(4'd8, 32'h99); e(1'b0, 6'd4, 32'h10c, 32'h8, 4'd7, 32'h77, 32'd2);
      e(1'b0, 6'd4, 32'h10c, 32'h8, 4'd7, 32'h77, 32'd2);
      ca(4'd8, 32'h9A); e(1'b0, 6'd4, 32'h10c, 32'h8, 4'd7, 32'h77, 32'd2);
      e(1'b1, 6'd5, 32'h110, 32'h0, 4'd8, 32'h9A, 32'd3);
      // dispatch while rdy=0 is dropped
      cur.rdy = 1'b0; d(6'd6, 32'h114, 32'h0, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
      e(1'b0, 6'd5, 32'h110, 32'h0, 4'd8, 32'h9A, 32'd3);
      e(1'b0, 6'd5, 32'h110, 32'h0, 4'd8, 32'h9A, 32'd3);
      e(1'b0, 6'd5, 32'h110, 32'h0, 4'd8, 32'h9A, 32'd3);

      idle_in();
      rst = 1'b1;
      #3;
      chk("reset_en", 32'(alu_enable), 32'd0);
      chk("reset_full", 32'(rs_full), 32'd0);
      chk("reset_rd", 32'(out_rd_rename), 32'd0);
      chk("reset_rs1", out_rs1_value, 32'd0);
      #9 rst = 1'b0;
      tick();

      foreach (tbl[k]) begin
         vec_t r;
         r = tbl[k];
         rdy = r.rdy; dispatch_valid = r.dv; dispatch_op = r.op; dispatch_pc = r.pc; dispatch_imm = r.imm;
         dispatch_rd_rename = r.rd;
         dispatch_rs1_ready = r.r1; dispatch_rs1_value = r.v1; dispatch_rs1_rename = r.t1;
         dispatch_rs2_ready = r.r2; dispatch_rs2_value = r.v2; dispatch_rs2_rename = r.t2;
         alu_cdb_valid = r.av; alu_cdb_rename = r.at; alu_cdb_value = r.ad;
         lsb_cdb_valid = r.lv; lsb_cdb_rename = r.lt; lsb_cdb_value = r.ld;
         tick();
         chk($sformatf("row%0d_en", k), 32'(alu_enable), 32'(r.e_en));
         chk($sformatf("row%0d_full", k), 32'(rs_full), 32'd0);
         chk($sformatf("row%0d_op", k), 32'(out_op), 32'(r.e_op));
         chk($sformatf("row%0d_pc", k), out_pc, r.e_pc);
         chk($sformatf("row%0d_imm", k), out_imm, r.e_imm);
         chk($sformatf("row%0d_rd", k), 32'(out_rd_rename), 32'(r.e_rd));
         chk($sformatf("row%0d_rs1", k), out_rs1_value, r.e_v1);
         chk($sformatf("row%0d_rs2", k), out_rs2_value, r.e_v2);
      end

      // fill all 16 entries; entry 5 waits on tag 11, the rest on tag 10
      idle_in();
      for (int i = 0; i < 16; i++) begin
         drv_disp(6'd7, 32'h200 + 32'(4 * i), 4'(i), 1'b0, 32'h0, (i == 5) ? 4'd11 : 4'd10, 1'b1, 32'(i), 4'd0);
         tick();
         chk($sformatf("fill%0d_full", i), 32'(rs_full), (i == 15) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d_en", i), 32'(alu_enable), 32'd0);
      end
      drv_disp(6'd8, 32'h300, 4'd15, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
      tick();
      idle_in();
      chk("full17_full", 32'(rs_full), 32'd1);
      tick();
      chk("full17_en_a", 32'(alu_enable), 32'd0);
      tick();
      chk("full17_en_b", 32'(alu_enable), 32'd0);
      alu_cdb_valid = 1'b1; alu_cdb_rename = 4'd11; alu_cdb_value = 32'h11;
      tick();
      idle_in();
      chk("wake5_en_early", 32'(alu_enable), 32'd0);
      chk("wake5_full_still", 32'(rs_full), 32'd1);
      tick();
      chk("wake5_en", 32'(alu_enable), 32'd1);
      chk("wake5_rd", 32'(out_rd_rename), 32'd5);
      chk("wake5_rs1", out_rs1_value, 32'h11);
      chk("wake5_rs2", out_rs2_value, 32'd5);
      chk("wake5_op", 32'(out_op), 32'd7);
      chk("wake5_full_clr", 32'(rs_full), 32'd0);
      tick();
      chk("wake5_en_after", 32'(alu_enable), 32'd0);

      // flush the 15 remaining entries, then their tag is broadcast with no effect
      jump_wrong = 1'b1;
      tick();
      idle_in();
      chk("flush15_full", 32'(rs_full), 32'd0);
      alu_cdb_valid = 1'b1; alu_cdb_rename = 4'd10; alu_cdb_value = 32'h10;
      tick();
      idle_in();
      tick();
      chk("flush15_no_issue", 32'(alu_enable), 32'd0);

      // 5 busy entries, flush with a simultaneous ready dispatch
      for (int i = 0; i < 5; i++) begin
         drv_disp(6'd9, 32'h400 + 32'(4 * i), 4'(i), 1'b0, 32'h0, 4'd12, 1'b1, 32'h0, 4'd0);
         tick();
      end
      drv_disp(6'd10, 32'h500, 4'd13, 1'b1, 32'h3, 4'd0, 1'b1, 32'h4, 4'd0);
      jump_wrong = 1'b1;
      tick();
      idle_in();
      chk("flush5_en", 32'(alu_enable), 32'd0);
      chk("flush5_full", 32'(rs_full), 32'd0);
      alu_cdb_valid = 1'b1; alu_cdb_rename = 4'd12; alu_cdb_value = 32'h12;
      lsb_cdb_valid = 1'b1; lsb_cdb_rename = 4'd12; lsb_cdb_value = 32'h12;
      tick();
      idle_in();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("flush5_quiet%0d", i), 32'(alu_enable), 32'd0);
      end

      // entries 2 and 6 woken together; rdy low for 3 cycles right after the wake-up
      for (int i = 0; i < 8; i++) begin
         drv_disp(6'd11, 32'h600 + 32'(4 * i), 4'(i), 1'b0, 32'h0, (i == 2 || i == 6) ? 4'd13 : 4'd14,
                  1'b1, 32'(i * 256), 4'd0);
         tick();
      end
      idle_in();
      alu_cdb_valid = 1'b1; alu_cdb_rename = 4'd13; alu_cdb_value = 32'h13;
      tick();
      idle_in();
      chk("prio_wake_en", 32'(alu_enable), 32'd0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("prio_stall%0d_en", i), 32'(alu_enable), 32'd0);
      end
      rdy = 1'b1;
      tick();
      chk("prio_first_en", 32'(alu_enable), 32'd1);
      chk("prio_first_rd", 32'(out_rd_rename), 32'd2);
      chk("prio_first_rs2", out_rs2_value, 32'h200);
      chk("prio_first_rs1", out_rs1_value, 32'h13);
      tick();
      chk("prio_second_en", 32'(alu_enable), 32'd1);
      chk("prio_second_rd", 32'(out_rd_rename), 32'd6);
      chk("prio_second_rs2", out_rs2_value, 32'h600);
      tick();
      chk("prio_done_en", 32'(alu_enable), 32'd0);

      // asynchronous reset with 6 entries still waiting on tag 14
      #2 rst = 1'b1;
      #1;
      chk("midrst_rd", 32'(out_rd_rename), 32'd0);
      chk("midrst_pc", out_pc, 32'd0);
      #2 rst = 1'b0;
      alu_cdb_valid = 1'b1; alu_cdb_rename = 4'd14; alu_cdb_value = 32'h14;
      tick();
      idle_in();
      tick();
      chk("midrst_no_issue", 32'(alu_enable), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Out-of-order scheduling buffer directly upstream of the ALU.
- Accepts renamed ALU/branch/jump instructions from dispatch and holds them until both source operands are valid.
- Snoops the ALU and LSB broadcast buses for operand wake-up.
- Issues at most one ready instruction per cycle to the ALU over the existing alu_enable / operand interface.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32).
- ROB_W, 4, ROB index width (rename tag width).
- OP_W, 6, internal opcode width.
- DATA_W, 32, data/address/immediate width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global ready; low freezes the block.
- jump_wrong  in  1  misprediction flush from ROB.
- dispatch_valid  in  1  new instruction present this cycle.
- dispatch_op  in  OP_W  opcode.
- dispatch_pc  in  DATA_W  instruction PC.
- dispatch_imm  in  DATA_W  sign-extended immediate.
- dispatch_rd_rename  in  ROB_W  destination ROB tag.
- dispatch_rs1_ready  in  1  rs1 value valid.
- dispatch_rs1_value  in  DATA_W  rs1 value.
- dispatch_rs1_rename  in  ROB_W  rs1 producer tag.
- dispatch_rs2_ready, dispatch_rs2_value, dispatch_rs2_rename: same as rs1, for rs2.
- rs_full  out  1  no free entry.
- alu_cdb_valid  in  1  ALU broadcast valid.
- alu_cdb_rename  in  ROB_W  ALU broadcast tag.
- alu_cdb_value  in  DATA_W  ALU broadcast value.
- lsb_cdb_valid  in  1  LSB broadcast valid.
- lsb_cdb_rename  in  ROB_W  LSB broadcast tag.
- lsb_cdb_value  in  DATA_W  LSB broadcast value.
- alu_enable  out  1  issue strobe to ALU.
- out_rd_rename  out  ROB_W  issued destination tag.
- out_op  out  OP_W  issued opcode.
- out_pc  out  DATA_W  issued PC.
- out_imm  out  DATA_W  issued immediate.
- out_rs1_value  out  DATA_W  issued rs1 value.
- out_rs2_value  out  DATA_W  issued rs2 value.

Behaviour:
- Reset (async, rst=1): all entry busy bits cleared; alu_enable=0; all other outputs 0.
- Entry state: busy, op, pc, imm, rd_rename, and per source {ready, value, rename}.
- rs_full: combinational, =1 iff all RS_SIZE entries are busy.
- Dispatch:
  - When dispatch_valid and !rs_full, the instruction is written into the lowest-index free entry at the clock edge.
  - dispatch_valid while rs_full is ignored; upstream must not do this.
  - A slot freed by an issue this cycle is not reusable until the next cycle.
- Dispatch bypass: if a source is not ready and its rename matches a valid CDB tag in the same cycle, that source is stored ready with the CDB value. If both buses match, the ALU bus wins.
- Wake-up: each cycle, every busy entry with a non-ready source whose rename matches a valid CDB tag sets ready and captures the value.
- Issue select:
  - Uses registered state only; a same-cycle wake-up does not enable a same-cycle issue.
  - The lowest-index busy entry with both sources ready is chosen.
  - At the edge, all out_* regs load that entry's fields, alu_enable<=1, and the entry's busy bit is cleared.
  - No candidate: alu_enable<=0; out_* hold their previous values.
- Latency:
  - Dispatch with both operands ready at edge N → alu_enable=1 after edge N+1.
  - Broadcast at edge-N cycle → dependent issue after edge N+1 at the earliest.
- Operands: single-source and no-source ops (LUI, AUIPC, JAL, I-type) are dispatched with the unused source ready=1, value 0. The RS does not inspect op.
- Flush: jump_wrong=1 (with rdy=1) at an edge clears all busy bits and sets alu_enable<=0. Any simultaneous dispatch is dropped. Flush has priority over dispatch, wake-up and issue.
- rdy=0: no dispatch, wake-up or issue; alu_enable<=0; entry state held. Broadcasts in that cycle are not captured (producers are also stalled).
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro: RS_PERF_COUNTER_EN.
- When defined, adds two outputs:
  - perf_issue_cnt (32b): increments on every edge where alu_enable is loaded to 1.
  - perf_full_cnt (32b): increments on every edge with rdy=1 and rs_full=1.
  - Both reset to 0 on rst; not cleared by jump_wrong; wrap at 2^32.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Dispatch ADD, rs1=5 ready, rs2=7 ready, rd=3 → next cycle alu_enable=1, out_op=ADD, out_rs1_value=5, out_rs2_value=7, out_rd_rename=3; one cycle later alu_enable=0.
- Dispatch SUB with rs1 waiting on tag 9; two cycles later alu_cdb_valid with tag 9, value 0x10 → issue on the following edge with out_rs1_value=0x10. No issue before that.
- Dispatch with rs2 tag 4 in the same cycle as lsb_cdb tag 4, value 0xAB → stored ready; issues next cycle with out_rs2_value=0xAB.
- Fill all 16 entries with unready ops → rs_full=1. A 17th dispatch is dropped. Wake one entry → it issues, and rs_full=0 the cycle after.
- With 5 busy entries, assert jump_wrong with dispatch_valid → all entries cleared, alu_enable=0, nothing issues afterwards.
- Two entries become ready in the same cycle, at indices 2 and 6 → index 2 issues first, index 6 on the next edge. Holding rdy=0 for 3 cycles delays both issues by exactly 3 cycles.
